blocking_pipe_pair: RTL and testbench

//   Sandbox block with two 8-bit, 3-stage register chains driven by one input d.
//   - Chain B1 (collapsed): stage order q1<-d, q2<-q1, q3<-q2, each stage seeing
//     the value written earlier in the same edge. Net result is ONE register of

---
 rtl/blocking_pipe_pair.sv | 59 +++++
 tb/tb_blocking_pipe_pair.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/blocking_pipe_pair.sv
// Purpose: two WIDTH-bit register chains fed by one input: B1 collapses to a single register, B2 is a true DEPTH-stage pipeline.
// Latency: q3_b1 lags d by 1 cycle, q3_b2 by DEPTH cycles; vld_b1/vld_b2 mark when each output holds sampled data.
// Backpressure: none; d is sampled every rising edge unconditionally, synchronous active-high reset discards in-flight data.
module blocking_pipe_pair #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q3_b1,
  output logic [WIDTH-1:0] q3_b2,
  output logic             vld_b1,
  output logic             vld_b2
);

  // B1 models the blocking-ordered chain: every stage sees the freshly written
  // value, so all stages collapse onto d and hold identical contents.
  logic [WIDTH-1:0] r_b1 [DEPTH];
  // B2 is the genuine shift pipeline; each stage reads its neighbour's pre-edge value.
  logic [WIDTH-1:0] r_b2 [DEPTH];
  logic             r_vld_b1;
  // One valid bit travels alongside each B2 stage so vld_b2 follows the data
  // front after reset release and restarts from scratch on a mid-stream reset.
  logic [DEPTH-1:0] r_vld_b2;

  // Collapsed chain B1: all stages load d together; reset wins over data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_b1[i] <= '0;
      r_vld_b1 <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_b1[i] <= d;
      r_vld_b1 <= 1'b1;
    end
  end

  // True pipeline B2 with its shift-valid chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_b2[i] <= '0;
      r_vld_b2 <= '0;
    end else begin
      r_b2[0]     <= d;
      r_vld_b2[0] <= 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        r_b2[i]     <= r_b2[i-1];
        r_vld_b2[i] <= r_vld_b2[i-1];
      end
    end
  end

  // Outputs come straight from the last stage registers: no d -> q combinational path.
  assign q3_b1  = r_b1[DEPTH-1];
  assign q3_b2  = r_b2[DEPTH-1];
  assign vld_b1 = r_vld_b1;
  assign vld_b2 = r_vld_b2[DEPTH-1];

endmodule

// File: tb/tb_blocking_pipe_pair.sv
// Purpose: self-checking bench for blocking_pipe_pair using a vector table plus short hand-written sequences.
// Latency: inputs change 1 time unit after each rising edge, outputs are sampled 1 time unit after the edge.
// Backpressure: none; the design accepts d on every edge.
module tb_blocking_pipe_pair;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [7:0] q3_b1;
  logic [7:0] q3_b2;
  logic       vld_b1;
  logic       vld_b2;

  int checks = 0;
  int errors = 0;

  blocking_pipe_pair #(.WIDTH(8), .DEPTH(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .q3_b1  (q3_b1),
    .q3_b2  (q3_b2),
    .vld_b1 (vld_b1),
    .vld_b2 (vld_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic [7:0] e_b1;
    logic [7:0] e_b2;
    logic       e_v1;
    logic       e_v2;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  // Compare one observed value against its expectation; X or Z counts as a miss.
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic [7:0] e1, input logic [7:0] e2,
                         input logic ev1, input logic ev2);
    chk("q3_b1", idx, q3_b1, e1);
    chk("q3_b2", idx, q3_b2, e2);
    chk("vld_b1", idx, {7'd0, vld_b1}, {7'd0, ev1});
    chk("vld_b2", idx, {7'd0, vld_b2}, {7'd0, ev2});
  endtask

  logic [7:0] hist [$];
  logic [7:0] nd;

  initial begin
    // Row = {rst, d applied before the edge, q3_b1, q3_b2, vld_b1, vld_b2 after the edge}
    vecs[0]  = '{1'b1, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h02, 8'h02, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h03, 8'h03, 8'h01, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h04, 8'h04, 8'h02, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h05, 8'h05, 8'h03, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h06, 8'h06, 8'h04, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h07, 8'h07, 8'h05, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h08, 8'h08, 8'h06, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h09, 8'h09, 8'h07, 1'b1, 1'b1};
    // mid-stream reset with q3_b2 = 07: reset wins over d, everything clears
    vecs[11] = '{1'b1, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'hA0, 8'hA0, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'hA1, 8'hA1, 8'h00, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'hFF, 8'hFF, 8'hA0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 8'h00, 8'hA1, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 8'h11, 8'h11, 8'hFF, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 8'h22, 8'h22, 8'h00, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 8'h33, 8'h33, 8'h11, 1'b1, 1'b1};

    rst = 1'b1;
    d   = 8'h55;
    #1;

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst;
      d   = vecs[i].d;
      step();
      chk_all(i, vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_v1, vecs[i].e_v2);
    end

    // d wiggling between edges: only the value present at the edge is captured.
    // Pipeline now holds 33 (stage0), 22 (stage1), 11 (stage2).
    d = 8'h5A;
    #3;
    d = 8'h96;
    #2;
    d = 8'hC3;
    step();
    chk("glitch_b1", 100, q3_b1, 8'hC3);
    chk("glitch_b2", 100, q3_b2, 8'h22);

    // Free run with random data: q3_b1 is the last d, q3_b2 is d from 3 edges back.
    hist.push_back(8'h22);
    hist.push_back(8'h33);
    hist.push_back(8'hC3);
    for (int n = 0; n < 24; n++) begin
      nd = 8'($urandom_range(0, 255));
      d  = nd;
      hist.push_back(nd);
      step();
      chk("run_b1", 200 + n, q3_b1, hist[hist.size()-1]);
      chk("run_b2", 200 + n, q3_b2, hist[hist.size()-3]);
      chk("run_vld", 200 + n, {6'd0, vld_b1, vld_b2}, 8'h03);
    end

    // Single-edge reset pulse, then count edges until vld_b2 returns.
    rst = 1'b1;
    d   = 8'h77;
    step();
    chk_all(300, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    d   = 8'h10;
    step();
    chk_all(301, 8'h10, 8'h00, 1'b1, 1'b0);
    d = 8'h20;
    step();
    chk_all(302, 8'h20, 8'h00, 1'b1, 1'b0);
    d = 8'h30;
    step();
    chk_all(303, 8'h30, 8'h10, 1'b1, 1'b1);
    d = 8'h40;
    step();
    chk_all(304, 8'h40, 8'h20, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
